// File: rtl/myproject_mul_pipe_fxp.sv
// Pipelined fixed-point multiplier: per-operand signedness, scaled right shift with optional
// round-half-up, wrap or saturate to dout_WIDTH with overflow flag, valid/ready with full stall.
module myproject_mul_pipe_fxp #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 2,
  parameter int din0_WIDTH  = 16,
  parameter int din1_WIDTH  = 13,
  parameter int din0_SIGNED = 1,
  parameter int din1_SIGNED = 0,
  parameter int dout_WIDTH  = 16,
  parameter int SHIFT       = 10,
  parameter int ROUND       = 1,
  parameter int SAT         = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  // Working width: exact product (W0+W1+1) plus one guard bit so the rounding add cannot overflow.
  localparam int RW = din0_WIDTH + din1_WIDTH + 2;
  localparam int CW = ((RW > dout_WIDTH) ? RW : dout_WIDTH) + 2;
  localparam bit RES_SIGNED = (din0_SIGNED != 0) || (din1_SIGNED != 0);
  localparam int NMID = (NUM_STAGE > 2) ? NUM_STAGE - 2 : 1;

  localparam logic signed [RW-1:0] R_ONE = 1;
  localparam logic signed [RW-1:0] HALF =
    (ROUND != 0 && SHIFT > 0) ? (R_ONE <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [CW-1:0] C_ONE = 1;
  localparam logic signed [CW-1:0] MAX_V =
    RES_SIGNED ? (C_ONE <<< (dout_WIDTH - 1)) - C_ONE : (C_ONE <<< dout_WIDTH) - C_ONE;
  localparam logic signed [CW-1:0] MIN_V =
    RES_SIGNED ? -(C_ONE <<< (dout_WIDTH - 1)) : '0;

  if (NUM_STAGE < 1 || NUM_STAGE > 4 || SHIFT < 0 ||
      SHIFT >= din0_WIDTH + din1_WIDTH || ID < 0) begin : g_param_check
    $error("myproject_mul_pipe_fxp: illegal parameter combination");
  end

  // Unsigned operands get a zero bit on top so one signed multiplier serves every mode.
  function automatic logic signed [RW-1:0] ext0(input logic [din0_WIDTH-1:0] x);
    logic s;
    s = (din0_SIGNED != 0) && x[din0_WIDTH-1];
    return {{(RW-din0_WIDTH){s}}, x};
  endfunction

  function automatic logic signed [RW-1:0] ext1(input logic [din1_WIDTH-1:0] x);
    logic s;
    s = (din1_SIGNED != 0) && x[din1_WIDTH-1];
    return {{(RW-din1_WIDTH){s}}, x};
  endfunction

  logic                  advance;
  logic                  fin_valid;
  logic signed [RW-1:0]  fin_prod;
  logic signed [RW-1:0]  rounded;
  logic signed [RW-1:0]  shifted;
  logic signed [CW-1:0]  wide;
  logic                  fit;
  logic [dout_WIDTH-1:0] dout_next;

  assign advance   = !dout_valid || dout_ready;
  assign din_ready = advance;

  if (NUM_STAGE == 1) begin : g_direct
    assign fin_valid = din_valid;
    assign fin_prod  = ext0(din0) * ext1(din1);
  end else begin : g_staged
    logic                 a_valid_reg;
    logic signed [RW-1:0] a_reg;
    logic signed [RW-1:0] b_reg;

    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        a_valid_reg <= 1'b0;
      end else if (advance) begin
        a_valid_reg <= din_valid;
      end
    end

    always_ff @(posedge ap_clk) begin
      if (advance) begin
        a_reg <= ext0(din0);
        b_reg <= ext1(din1);
      end
    end

    if (NUM_STAGE == 2) begin : g_no_mid
      assign fin_valid = a_valid_reg;
      assign fin_prod  = a_reg * b_reg;
    end else begin : g_mid
      // First middle stage multiplies; any further middle stages only delay the product.
      logic [NMID-1:0]      mid_valid_reg;
      logic signed [RW-1:0] mid_reg [NMID];

      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          mid_valid_reg <= '0;
        end else if (advance) begin
          mid_valid_reg[0] <= a_valid_reg;
          for (int i = 1; i < NMID; i++) begin
            mid_valid_reg[i] <= mid_valid_reg[i-1];
          end
        end
      end

      always_ff @(posedge ap_clk) begin
        if (advance) begin
          mid_reg[0] <= a_reg * b_reg;
          for (int i = 1; i < NMID; i++) begin
            mid_reg[i] <= mid_reg[i-1];
          end
        end
      end

      assign fin_valid = mid_valid_reg[NMID-1];
      assign fin_prod  = mid_reg[NMID-1];
    end
  end

  always_comb begin
    rounded   = fin_prod + HALF;
    shifted   = rounded >>> SHIFT;
    wide      = CW'(shifted);
    fit       = (wide >= MIN_V) && (wide <= MAX_V);
    dout_next = wide[dout_WIDTH-1:0];
    if (!fit && SAT != 0) begin
      dout_next = (wide < MIN_V) ? MIN_V[dout_WIDTH-1:0] : MAX_V[dout_WIDTH-1:0];
    end
  end

  // dout/ovf only load on a valid result so they keep the last value across bubbles.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      ovf        <= 1'b0;
    end else if (advance) begin
      dout_valid <= fin_valid;
      if (fin_valid) begin
        dout <= dout_next;
        ovf  <= !fit;
      end
    end
  end

endmodule

// File: tb/tb_myproject_mul_pipe_fxp.sv
// Bench for myproject_mul_pipe_fxp: directed cases on the default build plus randomized
// streams on several configurations, all checked against an arithmetic reference model.
module tb_myproject_mul_pipe_fxp;

  typedef struct {
    longint q;
    bit     o;
    int     acc;
  } exp_t;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic mark_done();
    done_cnt++;
  endtask

  // Reference: exact integer product, optional +2^(sh-1), floor shift, then clamp or wrap.
  function automatic void model(input int w0, input int w1, input int s0, input int s1,
                                input int wo, input int sh, input int rnd, input int sat,
                                input longint ra, input longint rb,
                                output longint q, output bit o);
    longint a, b, p, lo, hi;
    a = (s0 != 0 && ra[w0-1]) ? ra - (longint'(1) << w0) : ra;
    b = (s1 != 0 && rb[w1-1]) ? rb - (longint'(1) << w1) : rb;
    p = a * b;
    if (rnd != 0 && sh > 0) p = p + (longint'(1) << (sh - 1));
    p = p >>> sh;
    if (s0 != 0 || s1 != 0) begin
      lo = -(longint'(1) << (wo - 1));
      hi = (longint'(1) << (wo - 1)) - 1;
    end else begin
      lo = 0;
      hi = (longint'(1) << wo) - 1;
    end
    o = (p < lo) || (p > hi);
    if (sat != 0 && p < lo) p = lo;
    else if (sat != 0 && p > hi) p = hi;
    q = p & ((longint'(1) << wo) - 1);
  endfunction

  // Default build (m_*) and a truncate/wrap build (a_*) share the same stimulus.
  logic        m_rst, m_valid, m_ready;
  logic [15:0] m_d0;
  logic [12:0] m_d1;
  logic        m_din_ready, m_dout_valid, m_ovf;
  logic [15:0] m_dout;
  logic        a_din_ready, a_dout_valid, a_ovf;
  logic [15:0] a_dout;

  myproject_mul_pipe_fxp u_dut (
    .ap_clk(clk), .ap_rst(m_rst), .din_valid(m_valid), .din_ready(m_din_ready),
    .din0(m_d0), .din1(m_d1), .dout_valid(m_dout_valid), .dout_ready(m_ready),
    .dout(m_dout), .ovf(m_ovf)
  );

  myproject_mul_pipe_fxp #(.ROUND(0), .SAT(0)) u_alt (
    .ap_clk(clk), .ap_rst(m_rst), .din_valid(m_valid), .din_ready(a_din_ready),
    .din0(m_d0), .din1(m_d1), .dout_valid(a_dout_valid), .dout_ready(m_ready),
    .dout(a_dout), .ovf(a_ovf)
  );

  task automatic send_pair(input string nm, input logic [15:0] d0, input logic [12:0] d1,
                           input longint eq, input bit eo, input longint aq, input bit ao);
    m_d0 = d0; m_d1 = d1; m_valid = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    m_valid = 1'b0;
    check({nm, "_valid_early"}, m_dout_valid, 0);
    @(negedge clk);
    check({nm, "_valid"}, m_dout_valid, 1);
    check({nm, "_dout"}, m_dout, eq);
    check({nm, "_ovf"}, m_ovf, eo);
    check({nm, "_alt_dout"}, a_dout, aq);
    check({nm, "_alt_ovf"}, a_ovf, ao);
    @(negedge clk);
  endtask

  initial begin : directed
    longint q;
    bit o;
    int k_sent, k_got, c, guard;
    bit stall, seen;
    logic [15:0] held;

    m_rst = 1'b1; m_valid = 1'b0; m_ready = 1'b1; m_d0 = '0; m_d1 = '0;

    // Pin the reference model against hand-computed values.
    model(16, 13, 1, 0, 16, 10, 1, 1, 1000, 2048, q, o);   check("model_t1", q, 2000);
    model(16, 13, 1, 0, 16, 10, 1, 1, 3, 171, q, o);       check("model_round", q, 1);
    model(16, 13, 1, 0, 16, 10, 0, 1, 3, 171, q, o);       check("model_trunc", q, 0);
    model(16, 13, 1, 0, 16, 10, 1, 1, 32768, 8191, q, o);  check("model_satmin", q, 32768);
    model(16, 13, 1, 0, 16, 10, 0, 0, 32767, 8191, q, o);  check("model_wrapmax", q, 65496);
    check("model_wrapmax_ovf", o, 1);

    repeat (2) @(negedge clk);
    check("rst_dout_valid", m_dout_valid, 0);
    check("rst_dout", m_dout, 0);
    check("rst_ovf", m_ovf, 0);
    m_rst = 1'b0;
    #1 check("rst_din_ready", m_din_ready, 1);
    @(negedge clk);

    send_pair("t1", 16'd1000, 13'd2048, 2000, 0, 2000, 0);
    send_pair("t2", 16'd3, 13'd171, 1, 0, 0, 0);
    send_pair("t3_min", 16'h8000, 13'd8191, 16'h8000, 1, 16'h0020, 1);
    send_pair("t3_max", 16'd32767, 13'd8191, 16'h7FFF, 1, 16'hFFD8, 1);

    // Stream of 8 back-to-back pairs with dout_ready low for cycles 3..5.
    k_sent = 0; k_got = 0; c = 0; stall = 1'b0; held = '0;
    while (k_got < 8 && c < 40) begin
      if (stall) begin
        check("t4_stall_valid", m_dout_valid, 1);
        check("t4_stall_dout", m_dout, held);
      end
      m_ready = !(c >= 3 && c <= 5);
      m_valid = (k_sent < 8);
      m_d0 = 16'((k_sent + 1) * 100);
      m_d1 = 13'd1024;
      #1;
      check("t4_din_ready", m_din_ready, !m_dout_valid || m_ready);
      if (c >= 3 && c <= 5) check("t4_stall_din_ready", m_din_ready, 0);
      if (m_dout_valid && m_ready) begin
        check("t4_dout", m_dout, (k_got + 1) * 100);
        k_got++;
      end
      if (m_valid && m_din_ready) k_sent++;
      stall = m_dout_valid && !m_ready;
      held = m_dout;
      @(negedge clk);
      c++;
    end
    m_valid = 1'b0;
    check("t4_count", k_got, 8);
    @(negedge clk);
    check("t4_no_extra", m_dout_valid, 0);

    // Reset with two items in flight (one parked on dout, one in stage 1).
    m_ready = 1'b0; m_valid = 1'b1; m_d0 = 16'd32767; m_d1 = 13'd8191;
    @(negedge clk);
    m_d0 = 16'd1000; m_d1 = 13'd2048;
    @(negedge clk);
    m_valid = 1'b0;
    check("t5_pre_valid", m_dout_valid, 1);
    check("t5_pre_ovf", m_ovf, 1);
    m_rst = 1'b1;
    @(negedge clk);
    check("t5_valid", m_dout_valid, 0);
    check("t5_dout", m_dout, 0);
    check("t5_ovf", m_ovf, 0);
    m_rst = 1'b0; m_ready = 1'b1; seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (m_dout_valid) seen = 1'b1;
    end
    check("t5_no_emerge", seen, 0);

    guard = 0;
    while (done_cnt < 5 && guard < 60000) begin
      @(negedge clk);
      guard++;
    end
    check("sweeps_done", done_cnt, 5);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Randomized sweep: latency 1..4, unsigned*unsigned and signed*signed, plus the default mix.
  for (genvar gi = 0; gi < 5; gi++) begin : g_sweep
    localparam int NS  = (gi == 4) ? 2 : gi + 1;
    localparam int S0  = (gi == 4) ? 1 : gi % 2;
    localparam int S1  = (gi == 4) ? 0 : gi % 2;
    localparam int W0  = (gi == 4) ? 16 : 12;
    localparam int W1  = (gi == 4) ? 13 : 9;
    localparam int WO  = (gi == 4) ? 16 : 12;
    localparam int SH  = (gi == 4) ? 10 : ((gi == 3) ? 0 : 5 + gi);
    localparam int RND = (gi == 4) ? 1 : ((gi < 2) ? 1 : 0);
    localparam int ST  = (gi == 4) ? 1 : ((gi == 0 || gi == 3) ? 1 : 0);
    localparam int N   = 3000;

    logic          rst, vin, rdy_in, vout, rdy_out, ov;
    logic [W0-1:0] a;
    logic [W1-1:0] b;
    logic [WO-1:0] q;
    exp_t          sb[$];

    myproject_mul_pipe_fxp #(
      .NUM_STAGE(NS), .din0_WIDTH(W0), .din1_WIDTH(W1), .din0_SIGNED(S0), .din1_SIGNED(S1),
      .dout_WIDTH(WO), .SHIFT(SH), .ROUND(RND), .SAT(ST)
    ) u_dut (
      .ap_clk(clk), .ap_rst(rst), .din_valid(vin), .din_ready(rdy_in),
      .din0(a), .din1(b), .dout_valid(vout), .dout_ready(rdy_out), .dout(q), .ovf(ov)
    );

    initial begin : run
      int sent, got, cyc, adv;
      bit stall, held_o;
      logic [WO-1:0] held_q;
      exp_t e;
      longint mq;
      bit mo;

      rst = 1'b1; vin = 1'b0; rdy_out = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check($sformatf("cfg%0d_rst_valid", gi), vout, 0);
      rst = 1'b0;
      sent = 0; got = 0; cyc = 0; adv = 0; stall = 1'b0; held_o = 1'b0; held_q = '0;
      while (got < N && cyc < N * 6) begin
        if (stall) begin
          check($sformatf("cfg%0d_hold_valid", gi), vout, 1);
          check($sformatf("cfg%0d_hold_dout", gi), q, held_q);
          check($sformatf("cfg%0d_hold_ovf", gi), ov, held_o);
        end
        vin = (sent < N) && ($urandom_range(0, 4) != 0);
        rdy_out = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 7))
          0: a = '1;
          1: a = (S0 != 0) ? {1'b1, {(W0-1){1'b0}}} : '0;
          default: a = W0'($urandom);
        endcase
        case ($urandom_range(0, 7))
          0: b = '1;
          1: b = (S1 != 0) ? {1'b1, {(W1-1){1'b0}}} : '0;
          default: b = W1'($urandom);
        endcase
        #1;
        check($sformatf("cfg%0d_din_ready", gi), rdy_in, !vout || rdy_out);
        if (vout && rdy_out) begin
          if (sb.size() == 0) begin
            check($sformatf("cfg%0d_unexpected_out", gi), 1, 0);
          end else begin
            e = sb.pop_front();
            check($sformatf("cfg%0d_dout", gi), q, e.q);
            check($sformatf("cfg%0d_ovf", gi), ov, e.o);
            check($sformatf("cfg%0d_latency", gi), adv - e.acc, NS);
          end
          got++;
        end
        if (vin && rdy_in) begin
          model(W0, W1, S0, S1, WO, SH, RND, ST, longint'(a), longint'(b), mq, mo);
          e.q = mq; e.o = mo; e.acc = adv;
          sb.push_back(e);
          sent++;
        end
        stall = vout && !rdy_out;
        held_q = q;
        held_o = ov;
        if (rdy_in) adv++;
        @(negedge clk);
        cyc++;
      end
      check($sformatf("cfg%0d_received", gi), got, N);
      mark_done();
    end
  end

endmodule
